tmds_ser_to_par: RTL and testbench

//  Receive-side counterpart of the 10-bit TMDS serializer: deserializes one LSB-first TMDS

---
 rtl/tmds_pkg.sv | 18 +
 rtl/tmds_token_detect.sv | 25 ++
 rtl/tmds_ser_to_par.sv | 153 +++++++++++++++
 tb/tb_tmds_ser_to_par.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: word width, the four control-token codes and the
// lane-alignment state type. Token codes are written bit9..bit0, where bit0
// is the first bit on the wire.
package tmds_pkg;

  localparam int unsigned WORD_BITS = 10;

  localparam logic [WORD_BITS-1:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [WORD_BITS-1:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [WORD_BITS-1:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [WORD_BITS-1:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

endpackage

// File: rtl/tmds_token_detect.sv
// Combinational TMDS control-token recogniser.
//   word_i  : 10-bit word, bit0 = first bit received
//   match_o : word is one of the four control tokens
//   ctl_o   : {C1,C0} of the matched token, 0 when no match
module tmds_token_detect
  import tmds_pkg::*;
(
  input  logic [WORD_BITS-1:0] word_i,
  output logic                 match_o,
  output logic [1:0]           ctl_o
);

  always_comb begin
    match_o = 1'b1;
    ctl_o   = 2'b00;
    case (word_i)
      TOKEN_C00: ctl_o = 2'b00;
      TOKEN_C01: ctl_o = 2'b01;
      TOKEN_C10: ctl_o = 2'b10;
      TOKEN_C11: ctl_o = 2'b11;
      default:   match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_ser_to_par.sv
// TMDS lane deserializer with token-based word alignment (serial clock domain).
//   serial_clock   : bit clock, all logic on posedge
//   reset          : asynchronous, active-high
//   serial         : lane bit, LSB of each word first
//   resync         : synchronous request to drop back to SEARCH
//   parallel       : last aligned word (bit0 = first bit received)
//   parallel_valid : one-cycle pulse when parallel updates (LOCKED only)
//   is_control     : parallel holds a control token
//   control        : {C1,C0} of the last token emitted
//   locked         : alignment locked
module tmds_ser_to_par
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_TOKENS   = 4,
  parameter int unsigned TIMEOUT_WORDS = 4096
) (
  input  logic                 serial_clock,
  input  logic                 reset,
  input  logic                 serial,
  input  logic                 resync,
  output logic [WORD_BITS-1:0] parallel,
  output logic                 parallel_valid,
  output logic                 is_control,
  output logic [1:0]           control,
  output logic                 locked
);

  localparam int unsigned TOK_W = $clog2(LOCK_TOKENS + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_WORDS + 1);
  localparam logic [TOK_W-1:0] TOK_MAX    = TOK_W'(LOCK_TOKENS);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_WORDS);
  localparam logic [3:0]       PHASE_LAST = 4'(WORD_BITS - 1);

  state_t               state_q, state_d;
  // Only the 9 newest bits are stored; the 10th comes straight from serial.
  logic [WORD_BITS-2:0] hist_q, hist_d;
  logic [3:0]           phase_q, phase_d;
  logic [TOK_W-1:0]     tok_cnt_q, tok_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [WORD_BITS-1:0] parallel_q, parallel_d;
  logic                 valid_q, valid_d;
  logic                 is_ctl_q, is_ctl_d;
  logic [1:0]           ctl_q, ctl_d;

  logic [WORD_BITS-1:0] win_next;
  logic                 boundary;
  logic                 tok_match;
  logic [1:0]           tok_ctl;
  logic                 emit;

  assign win_next = {serial, hist_q};
  assign boundary = (phase_q == PHASE_LAST);

  tmds_token_detect u_detect (
    .word_i  (win_next),
    .match_o (tok_match),
    .ctl_o   (tok_ctl)
  );

  always_comb begin
    state_d    = state_q;
    hist_d     = win_next[WORD_BITS-1:1];
    phase_d    = boundary ? 4'd0 : phase_q + 4'd1;
    tok_cnt_d  = tok_cnt_q;
    to_cnt_d   = to_cnt_q;
    parallel_d = parallel_q;
    valid_d    = 1'b0;
    is_ctl_d   = is_ctl_q;
    ctl_d      = ctl_q;
    emit       = 1'b0;

    if (resync) begin
      state_d   = SEARCH;
      tok_cnt_d = '0;
      to_cnt_d  = '0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (tok_match) begin
            if (boundary) begin
              if (tok_cnt_q != TOK_MAX) tok_cnt_d = tok_cnt_q + 1'b1;
            end else begin
              // An off-boundary token ends a word right here: restart the
              // phase so the next word begins on the following bit.
              phase_d   = 4'd0;
              tok_cnt_d = TOK_W'(1);
            end
            if (tok_cnt_d == TOK_MAX) begin
              state_d  = LOCKED;
              to_cnt_d = '0;
              emit     = 1'b1;
            end
          end else if (boundary) begin
            tok_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (boundary) begin
            emit = 1'b1;
            if (tok_match) begin
              to_cnt_d = '0;
            end else if (to_cnt_q != TO_MAX) begin
              to_cnt_d = to_cnt_q + 1'b1;
            end
            if (to_cnt_d == TO_MAX) begin
              state_d   = SEARCH;
              tok_cnt_d = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (emit) begin
      parallel_d = win_next;
      valid_d    = 1'b1;
      is_ctl_d   = tok_match;
      if (tok_match) ctl_d = tok_ctl;
    end
  end

  always_ff @(posedge serial_clock or posedge reset) begin
    if (reset) begin
      state_q    <= SEARCH;
      hist_q     <= '0;
      phase_q    <= '0;
      tok_cnt_q  <= '0;
      to_cnt_q   <= '0;
      parallel_q <= '0;
      valid_q    <= 1'b0;
      is_ctl_q   <= 1'b0;
      ctl_q      <= '0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      phase_q    <= phase_d;
      tok_cnt_q  <= tok_cnt_d;
      to_cnt_q   <= to_cnt_d;
      parallel_q <= parallel_d;
      valid_q    <= valid_d;
      is_ctl_q   <= is_ctl_d;
      ctl_q      <= ctl_d;
    end
  end

  assign parallel       = parallel_q;
  assign parallel_valid = valid_q;
  assign is_control     = is_ctl_q;
  assign control        = ctl_q;
  assign locked         = (state_q == LOCKED);

endmodule

// File: tb/tb_tmds_ser_to_par.sv
module tb_tmds_ser_to_par;

  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic serial = 1'b0;
  logic resync = 1'b0;

  logic [9:0] par [2];
  logic       vld [2];
  logic       isc [2];
  logic [1:0] ctl [2];
  logic       lck [2];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Instance 0: LOCK_TOKENS=4, instance 1: LOCK_TOKENS=1; both see the same lane.
  tmds_ser_to_par #(.LOCK_TOKENS(4), .TIMEOUT_WORDS(TIMEOUT)) u_dut4 (
    .serial_clock(clk), .reset(reset), .serial(serial), .resync(resync),
    .parallel(par[0]), .parallel_valid(vld[0]), .is_control(isc[0]),
    .control(ctl[0]), .locked(lck[0]));

  tmds_ser_to_par #(.LOCK_TOKENS(1), .TIMEOUT_WORDS(TIMEOUT)) u_dut1 (
    .serial_clock(clk), .reset(reset), .serial(serial), .resync(resync),
    .parallel(par[1]), .parallel_valid(vld[1]), .is_control(isc[1]),
    .control(ctl[1]), .locked(lck[1]));

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h ({locked,valid,is_ctl,ctl,parallel})",
                  name, got, exp);
  endtask

  function automatic logic [15:0] dut_bundle(input int k);
    return {1'b0, lck[k], vld[k], isc[k], ctl[k], par[k]};
  endfunction

  // ---------------- reference model ----------------
  // Alignment is tracked as an anchor cycle: a word ends on every cycle n
  // with (n - anchor) % 10 == 9. The word is the last ten received bits.
  bit         hist[$];
  int         n_cyc = 0;
  int         m_anchor[2] = '{0, 0};
  int         m_tokc[2]   = '{0, 0};
  int         m_toc[2]    = '{0, 0};
  int         m_lockn[2]  = '{4, 1};
  bit         m_locked[2], m_valid[2], m_isc[2];
  bit [1:0]   m_ctl[2];
  bit [9:0]   m_par[2];

  function automatic int token_index(input logic [9:0] w);
    logic [9:0] tbl [4];
    tbl[0] = 10'b1101010100;
    tbl[1] = 10'b0010101011;
    tbl[2] = 10'b0101010100;
    tbl[3] = 10'b1010101011;
    for (int i = 0; i < 4; i++) if (w == tbl[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 10; i++) hist.push_back(1'b0);
    n_cyc = 0;
    for (int k = 0; k < 2; k++) begin
      m_anchor[k] = 0; m_tokc[k] = 0; m_toc[k] = 0;
      m_locked[k] = 0; m_valid[k] = 0; m_isc[k] = 0; m_ctl[k] = 0; m_par[k] = 0;
    end
  endtask

  task automatic model_emit(input int k, input logic [9:0] w, input int ti);
    m_par[k] = w; m_valid[k] = 1; m_isc[k] = (ti >= 0);
    if (ti >= 0) m_ctl[k] = 2'(ti);
  endtask

  task automatic model_step();
    logic [9:0] w;
    int ti;
    bit bnd;
    if (reset) begin
      model_reset();
      return;
    end
    hist.push_back(serial);
    if (hist.size() > 10) void'(hist.pop_front());
    for (int i = 0; i < 10; i++) w[i] = hist[i];
    ti = token_index(w);
    for (int k = 0; k < 2; k++) begin
      bnd = ((n_cyc - m_anchor[k]) % 10) == 9;
      m_valid[k] = 0;
      if (resync) begin
        m_locked[k] = 0; m_tokc[k] = 0; m_toc[k] = 0;
      end else if (!m_locked[k]) begin
        if (ti >= 0) begin
          if (bnd) begin
            if (m_tokc[k] < m_lockn[k]) m_tokc[k]++;
          end else begin
            m_anchor[k] = n_cyc + 1;
            m_tokc[k] = 1;
          end
          if (m_tokc[k] >= m_lockn[k]) begin
            m_locked[k] = 1; m_toc[k] = 0;
            model_emit(k, w, ti);
          end
        end else if (bnd) begin
          m_tokc[k] = 0;
        end
      end else if (bnd) begin
        model_emit(k, w, ti);
        if (ti >= 0) m_toc[k] = 0;
        else if (m_toc[k] < TIMEOUT) m_toc[k]++;
        if (m_toc[k] >= TIMEOUT) begin
          m_locked[k] = 0; m_tokc[k] = 0;
        end
      end
    end
    n_cyc++;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("cycle_L%0d", m_lockn[k]), dut_bundle(k),
            {1'b0, m_locked[k], m_valid[k], m_isc[k], m_ctl[k], m_par[k]});
  end

  // ---------------- stimulus ----------------
  task automatic send_bit(input logic b, input logic rs);
    @(negedge clk);
    serial = b;
    resync = rs;
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [9:0] w, input logic rs_last);
    for (int i = 0; i < 10; i++) send_bit(w[i], (i == 9) ? rs_last : 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    serial = 1'b0;
    resync = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_state_L4", dut_bundle(0), 16'h0000);
    check("reset_state_L1", dut_bundle(1), 16'h0000);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();

    // 1: token 00 at offset 3; L1 locks on first token, L4 on the fourth.
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    send_word(10'h354, 1'b0);
    check("t6_L1_first_token", dut_bundle(1), {1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 10'h354});
    check("t1_L4_not_yet", {15'h0, lck[0]}, 16'h0000);
    send_word(10'h354, 1'b0);
    send_word(10'h354, 1'b0);
    check("t1_L4_after3", {15'h0, lck[0]}, 16'h0000);
    send_word(10'h354, 1'b0);
    check("t1_L4_lock", dut_bundle(0), {1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 10'h354});
    send_word(10'h354, 1'b0);
    check("t1_L4_fifth", dut_bundle(0), {1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 10'h354});

    // 2: alternate token 11 and data 0x1F0.
    for (int r = 0; r < 2; r++) begin
      send_word(10'h2AB, 1'b0);
      check("t2_token11", dut_bundle(0), {1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 10'h2AB});
      send_word(10'h1F0, 1'b0);
      check("t2_data", dut_bundle(0), {1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 10'h1F0});
    end

    // 3: stray bit shifts tokens off boundary; timeout then relock.
    send_word(10'h354, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int t = 1; t <= 12; t++) begin
      send_word(10'h354, 1'b0);
      if (t == 7)  check("t3_still_locked", {15'h0, lck[0]}, 16'h0001);
      if (t == 8)  check("t3_timed_out", {15'h0, lck[0]}, 16'h0000);
      if (t == 10) check("t3_searching", {15'h0, lck[0]}, 16'h0000);
      if (t == 11) check("t3_relock", dut_bundle(0), {1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 10'h354});
    end

    // 4: resync on the lock-completing token.
    do_reset();
    for (int t = 0; t < 3; t++) send_word(10'h354, 1'b0);
    send_word(10'h354, 1'b1);
    check("t4_resync_lock", {14'h0, lck[0], vld[0]}, 16'h0000);
    for (int t = 0; t < 3; t++) send_word(10'h354, 1'b0);
    check("t4_after3", {15'h0, lck[0]}, 16'h0000);
    send_word(10'h354, 1'b0);
    check("t4_relock", dut_bundle(0), {1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 10'h354});

    // 5: asynchronous reset mid-word while locked.
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("t5_async_L4", dut_bundle(0), 16'h0000);
    check("t5_async_L1", dut_bundle(1), 16'h0000);
    do_reset();
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int t = 1; t <= 4; t++) begin
      send_word(10'h0AB, 1'b0);
      if (t == 1) check("t5_L1_lock", dut_bundle(1), {1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 10'h0AB});
      if (t == 3) check("t5_L4_after3", {15'h0, lck[0]}, 16'h0000);
      if (t == 4) check("t5_L4_relock", dut_bundle(0), {1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 10'h0AB});
    end
    send_word(10'h154, 1'b0);
    check("t5_token10", dut_bundle(0), {1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 10'h154});

    send_bit(1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
